serial_frame_rx: RTL and testbench

Serial-to-parallel frame receiver for the 8-bit serial pattern link. One bit per clock, LSB first, 8 bits per frame; this is the far end of the counter-driven 8:1 mux serializer. Received bytes are reported for one cycle, pushed into an 8-entry show-ahead FIFO, and can optionally be checked as thermometer codes.

---
 rtl/serial_frame_rx.sv | 166 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial LSB-first 8-bit frame receiver with an 8-entry show-ahead FIFO.
// Define THERM_CHECK_EN to build the thermometer-code check on therm_err.
module serial_frame_rx #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       din,
  output logic [2:0] bit_count,
  output logic       frame_valid,
  output logic [7:0] frame_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       therm_err
);

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_e;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  state_e state_q, state_d;

  logic       sample;
  logic [2:0] idx;
  logic       done;
  logic [7:0] byte_w;

  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_count_q, bit_count_d;
  logic       frame_valid_q, frame_valid_d;
  logic [7:0] frame_data_q, frame_data_d;

  logic [7:0]     mem_q [DEPTH];
  logic [7:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic empty_w, full_w, pop, push_ok, drop;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = CAPTURE;
      CAPTURE: if (!en) state_d = IDLE;
    endcase
  end

  always_comb begin
    sample = 1'b0;
    idx    = 3'd0;
    unique case (state_q)
      IDLE: begin
        sample = en;
        idx    = 3'd0;
      end
      CAPTURE: begin
        sample = en;
        idx    = bit_count_q;
      end
    endcase
  end

  // Bit 7 never lands in the shift register; it goes straight into the byte.
  always_comb begin
    byte_w      = {din, shift_q};
    done        = 1'b0;
    shift_d     = '0;
    bit_count_d = '0;
    if (sample) begin
      done        = (idx == 3'd7);
      shift_d     = done ? 7'd0 : (shift_q | (7'(din) << idx));
      bit_count_d = idx + 3'd1;
    end
  end

  always_comb begin
    frame_valid_d = done;
    frame_data_d  = done ? byte_w : frame_data_q;
  end

  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == CNT_FULL);
    pop     = rd_en & ~empty_w;
    push_ok = done & (~full_w | pop);
    drop    = done & full_w & ~pop;
  end

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wptr_q] = byte_w;
    wptr_d     = wptr_q + PTR_W'(push_ok);
    rptr_d     = rptr_q + PTR_W'(pop);
    count_d    = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q       <= '0;
      bit_count_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      mem_q         <= '{default: '0};
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_count_q   <= bit_count_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef THERM_CHECK_EN
  logic therm_ok;
  logic therm_err_q, therm_err_d;

  // Valid codes are 2^n-1: nonzero with no zero bit below the top set bit.
  always_comb begin
    therm_ok    = (byte_w != 8'h00) &&
                  ((byte_w & (byte_w + 8'h01)) == 8'h00);
    therm_err_d = done & ~therm_ok;
  end

  always_ff @(posedge clock) begin
    if (reset) therm_err_q <= 1'b0;
    else       therm_err_q <= therm_err_d;
  end

  assign therm_err = therm_err_q;
`else
  assign therm_err = 1'b0;
`endif

  assign bit_count   = bit_count_q;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign rd_data     = empty_w ? 8'h00 : mem_q[rptr_q];
  assign empty       = empty_w;
  assign full        = full_w;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: frame table plus pop,
// abort and mid-frame reset sequences.
module tb_serial_frame_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       din;
  logic [2:0] bit_count;
  logic       frame_valid;
  logic [7:0] frame_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       therm_err;

  int n_vec = 0;
  int n_err = 0;

  serial_frame_rx dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .din         (din),
    .bit_count   (bit_count),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .therm_err   (therm_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    logic       pop;
    logic       bad;
    logic [7:0] rd;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  vec_t vt [13];
  logic [7:0] pop_exp [8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  function automatic logic exp_therm(input logic bad);
`ifdef THERM_CHECK_EN
    return bad;
`else
    return 1'b0 & bad;
`endif
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic pop);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 8; i++) begin
      en    = 1'b1;
      din   = v[i];
      rd_en = (i == 7) ? pop : 1'b0;
      tick();
      if (i == 3) begin
        chk("mid_bit_count", 8'(bit_count), 8'd4);
        chk("mid_fv_low", 8'(frame_valid), 8'd0);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_bit_count"}, 8'(bit_count), 8'd0);
    chk({tag, "_fv"}, 8'(frame_valid), 8'd0);
    chk({tag, "_fd"}, frame_data, 8'h00);
    chk({tag, "_rd"}, rd_data, 8'h00);
    chk({tag, "_empty"}, 8'(empty), 8'd1);
    chk({tag, "_full"}, 8'(full), 8'd0);
    chk({tag, "_ovf"}, 8'(overflow), 8'd0);
    chk({tag, "_therm"}, 8'(therm_err), 8'd0);
  endtask

  initial begin
    vt[0]  = '{8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{8'h05, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{8'h03, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{8'h07, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{8'h0F, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{8'h1F, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{8'h3F, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{8'h7F, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[10] = '{8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
    vt[11] = '{8'h55, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
    vt[12] = '{8'h01, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1};
    pop_exp = '{8'h03, 8'h07, 8'h0F, 8'h1F,
                8'h3F, 8'h7F, 8'hFF, 8'h55};

    reset = 1'b1;
    en    = 1'b0;
    din   = 1'b0;
    rd_en = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b0;

    for (int k = 0; k < 13; k++) begin
      send_frame(vt[k].b, vt[k].pop);
      chk($sformatf("v%0d_fv", k), 8'(frame_valid), 8'd1);
      chk($sformatf("v%0d_fd", k), frame_data, vt[k].b);
      chk($sformatf("v%0d_bc", k), 8'(bit_count), 8'd0);
      chk($sformatf("v%0d_rd", k), rd_data, vt[k].rd);
      chk($sformatf("v%0d_empty", k), 8'(empty), 8'(vt[k].emp));
      chk($sformatf("v%0d_full", k), 8'(full), 8'(vt[k].ful));
      chk($sformatf("v%0d_ovf", k), 8'(overflow), 8'(vt[k].ovf));
      chk($sformatf("v%0d_therm", k), 8'(therm_err),
          8'(exp_therm(vt[k].bad)));
    end

    en = 1'b0;
    tick();
    chk("idle_fv_low", 8'(frame_valid), 8'd0);
    chk("idle_fd_hold", frame_data, 8'h01);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pop%0d_rd", i), rd_data, pop_exp[i]);
      rd_en = 1'b1;
      tick();
    end
    chk("drained_empty", 8'(empty), 8'd1);
    chk("drained_rd", rd_data, 8'h00);
    chk("drained_full", 8'(full), 8'd0);
    chk("drained_ovf_sticky", 8'(overflow), 8'd1);
    tick();
    rd_en = 1'b0;
    chk("pop_empty_ignored", 8'(empty), 8'd1);

    for (int i = 0; i < 4; i++) begin
      en  = 1'b1;
      din = 1'b1;
      tick();
    end
    chk("abort_pre_bc", 8'(bit_count), 8'd4);
    en = 1'b0;
    tick();
    chk("abort_bc", 8'(bit_count), 8'd0);
    chk("abort_fv", 8'(frame_valid), 8'd0);
    chk("abort_empty", 8'(empty), 8'd1);
    chk("abort_fd_hold", frame_data, 8'h01);
    send_frame(8'h3F, 1'b0);
    chk("after_abort_fv", 8'(frame_valid), 8'd1);
    chk("after_abort_fd", frame_data, 8'h3F);
    chk("after_abort_rd", rd_data, 8'h3F);
    chk("after_abort_empty", 8'(empty), 8'd0);

    send_frame(8'h01, 1'b0);
    send_frame(8'h03, 1'b0);
    chk("three_rd", rd_data, 8'h3F);
    for (int i = 0; i < 5; i++) begin
      en  = 1'b1;
      din = 1'b1;
      tick();
    end
    chk("pre_reset_bc", 8'(bit_count), 8'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("midrst");
    send_frame(8'h1F, 1'b0);
    chk("post_rst_fv", 8'(frame_valid), 8'd1);
    chk("post_rst_fd", frame_data, 8'h1F);
    chk("post_rst_rd", rd_data, 8'h1F);
    chk("post_rst_empty", 8'(empty), 8'd0);
    en = 1'b0;
    tick();
    chk("post_rst_fv_low", 8'(frame_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
